// File: rtl/sl_bus_arbiter_pkg.sv
// rtl/sl_bus_arbiter_pkg.sv - shared state encoding, slave bus layout and port helpers
package sl_bus_arbiter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETTLE  = 3'd1,
    ST_ADDR    = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_PRESENT = 3'd4,
    ST_RELEASE = 3'd5
  } state_t;

  localparam int EOF_BIT = 8;
  localparam int ADDR_W  = 9;
  localparam int SRC_W   = 3;

  function automatic logic [SRC_W-1:0] next_port(input logic [SRC_W-1:0] idx, input int num_ports);
    return (int'(idx) == num_ports - 1) ? '0 : idx + 1'b1;
  endfunction

endpackage

// File: rtl/sl_bus_arbiter_rr_select.sv
// rtl/sl_bus_arbiter_rr_select.sv - round-robin selector: first request at or after start
module rr_select
  import sl_bus_arbiter_pkg::*;
#(
  parameter int NUM_PORTS = 4
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [SRC_W-1:0]     start,
  output logic [NUM_PORTS-1:0] grant,
  output logic [SRC_W-1:0]     idx,
  output logic                 found
);

  logic [2*NUM_PORTS-1:0] doubled;
  logic [NUM_PORTS-1:0]   rotated;
  logic [SRC_W:0]         offset;
  logic [SRC_W:0]         sum;

  // rotated[k] is the request of port (start + k) mod NUM_PORTS
  always_comb begin
    doubled = {req, req} >> start;
    rotated = doubled[NUM_PORTS-1:0];
    found   = 1'b0;
    offset  = '0;
    for (int k = NUM_PORTS - 1; k >= 0; k--) begin
      if (rotated[k]) begin
        found  = 1'b1;
        offset = (SRC_W+1)'(k);
      end
    end
    sum   = {1'b0, start} + offset;
    if (int'(sum) >= NUM_PORTS) begin
      sum = sum - (SRC_W+1)'(NUM_PORTS);
    end
    idx   = sum[SRC_W-1:0];
    grant = found ? ({{(NUM_PORTS-1){1'b0}}, 1'b1} << idx) : '0;
  end

endmodule

// File: rtl/sl_bus_arbiter.sv
// rtl/sl_bus_arbiter.sv - round-robin slave-bus frame reader feeding a ready/valid byte stream
module sl_bus_arbiter
  import sl_bus_arbiter_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int MAX_WORDS = 511
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_PORTS-1:0] sl_arb_request,
  output logic [NUM_PORTS-1:0] sl_arb_grant,
  output logic [ADDR_W-1:0]    sl_addr,
  input  logic [8:0]           sl_data,
  output logic                 sl_latch_tail,
  output logic [7:0]           out_data,
  output logic [SRC_W-1:0]     out_src,
  output logic                 out_valid,
  output logic                 out_last,
  output logic                 out_err,
  input  logic                 out_ready
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MAX_WORDS - 1);
  localparam logic [ADDR_W-1:0] MAX_ADDR  = ADDR_W'(MAX_WORDS);

  state_t                 state_q, state_d;
  logic [NUM_PORTS-1:0]   grant_q, grant_d;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic                   latch_q, latch_d;
  logic [7:0]             data_q, data_d;
  logic [SRC_W-1:0]       src_q, src_d;
  logic                   valid_q, valid_d;
  logic                   last_q, last_d;
  logic                   err_q, err_d;
  logic                   abort_q, abort_d;
  logic [SRC_W-1:0]       ptr_q, ptr_d;

  logic [NUM_PORTS-1:0]   pick_grant;
  logic [SRC_W-1:0]       pick_idx;
  logic                   pick_found;
  logic                   req_live;
  logic                   transfer;
  logic                   emit_term;
  logic                   term_err;
  logic                   term_abort;

  rr_select #(.NUM_PORTS(NUM_PORTS)) u_rr_select (
    .req   (sl_arb_request),
    .start (ptr_q),
    .grant (pick_grant),
    .idx   (pick_idx),
    .found (pick_found)
  );

  assign req_live = |(sl_arb_request & grant_q);
  assign transfer = valid_q & out_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      addr_q  <= '0;
      latch_q <= 1'b0;
      data_q  <= '0;
      src_q   <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
      abort_q <= 1'b0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      addr_q  <= addr_d;
      latch_q <= latch_d;
      data_q  <= data_d;
      src_q   <= src_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      err_q   <= err_d;
      abort_q <= abort_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    addr_d     = addr_q;
    latch_d    = 1'b0;
    data_d     = data_q;
    src_d      = src_q;
    valid_d    = valid_q;
    last_d     = last_q;
    err_d      = err_q;
    abort_d    = abort_q;
    ptr_d      = ptr_q;
    emit_term  = 1'b0;
    term_err   = 1'b0;
    term_abort = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          grant_d = pick_grant;
          src_d   = pick_idx;
          ptr_d   = next_port(pick_idx, NUM_PORTS);
          addr_d  = '0;
          state_d = ST_SETTLE;
        end
      end
      ST_SETTLE, ST_ADDR: begin
        if (!req_live) begin
          emit_term  = 1'b1;
          term_err   = 1'b1;
          term_abort = 1'b1;
        end else begin
          state_d = (state_q == ST_SETTLE) ? ST_ADDR : ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        if (!req_live) begin
          emit_term  = 1'b1;
          term_err   = 1'b1;
          term_abort = 1'b1;
        end else if (sl_data[EOF_BIT]) begin
          emit_term = 1'b1;
        end else begin
          valid_d = 1'b1;
          data_d  = sl_data[7:0];
          last_d  = 1'b0;
          err_d   = 1'b0;
          state_d = ST_PRESENT;
        end
      end
      ST_PRESENT: begin
        if (transfer) begin
          valid_d = 1'b0;
          if (!req_live) begin
            emit_term  = 1'b1;
            term_err   = 1'b1;
            term_abort = 1'b1;
          end else if (addr_q == LAST_ADDR) begin
            addr_d    = MAX_ADDR;
            emit_term = 1'b1;
            term_err  = 1'b1;
          end else begin
            addr_d  = addr_q + 1'b1;
            state_d = ST_ADDR;
          end
        end
      end
      ST_RELEASE: begin
        // An aborted frame is never latched: the slave keeps it for a retry
        if (latch_q) begin
          grant_d = '0;
          state_d = ST_IDLE;
        end else if (transfer) begin
          valid_d = 1'b0;
          if (abort_q) begin
            grant_d = '0;
            state_d = ST_IDLE;
          end else begin
            latch_d = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (emit_term) begin
      valid_d = 1'b1;
      data_d  = '0;
      last_d  = 1'b1;
      err_d   = term_err;
      abort_d = term_abort;
      state_d = ST_RELEASE;
    end
  end

  assign sl_arb_grant  = grant_q;
  assign sl_addr       = addr_q;
  assign sl_latch_tail = latch_q;
  assign out_data      = data_q;
  assign out_src       = src_q;
  assign out_valid     = valid_q;
  assign out_last      = last_q;
  assign out_err       = err_q;

endmodule
